utopia_rx_port: RTL
===================

# utopia_rx_port

Per-port UTOPIA Level 1 receive front end for the 16-port squat16 ATM switch. One instance sits between each Rx Utopia PHY interface (`rxN_*`) and the switch core's cell input. It does the following:
- Runs the cell-level clav/en handshake with the PHY.
- Captures 53-byte cells into a two-entry ping-pong buffer.
- Checks the header HEC, dropping bad cells and framing errors.
- Streams good cells to the core over a valid/ready byte interface.

## Interface

Parameters:
- `CELL_BYTES`, default 53: bytes per cell. Header is bytes 0–3, HEC is byte 4.
- `HEC_COSET`, default 8'h55: value XORed onto the CRC-8 before comparison.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `rx_soc`  in  1  start of cell from the PHY, valid on capture edges.
- `rx_data`  in  8  cell byte from the PHY.
- `rx_clav`  in  1  PHY has a complete cell available.
- `rx_en`  out  1  active-low read enable to the PHY. Registered.
- `out_data`  out  8  cell byte to the core.
- `out_sop`  out  1  marks byte 0 of a cell on `out_data`.
- `out_eop`  out  1  marks byte `CELL_BYTES-1` on `out_data`.
- `out_valid`  out  1  `out_data`, `out_sop` and `out_eop` are valid.
- `out_ready`  in  1  core accepts the byte.
- `cell_cnt`  out  `CNT_W`  number of good cells committed. Saturating.
- `hec_err_cnt`  out  `CNT_W`  number of cells dropped for HEC mismatch. Saturating.
- `runt_cnt`  out  `CNT_W`  number of cells aborted by an early `rx_soc`. Saturating.

## Operation

Capture edge: any rising edge at which the registered `rx_en` is 0. On a capture edge the block samples `rx_soc` and `rx_data`.

Receive FSM:
- **IDLE**
  - `rx_en`=1.
  - Go to HUNT and drive `rx_en`=0 at the next edge when `rx_clav`=1 and at least one buffer is free.
- **HUNT**
  - `rx_en`=0.
  - Capture with `rx_soc`=0: drop the byte and stay in HUNT.
  - Capture with `rx_soc`=1: write the byte as index 0, load the CRC with the byte, go to RECV with index=1.
- **RECV**
  - `rx_en`=0.
  - Each capture writes `rx_data` at the current index, then increments the index.
  - Indices 1–3: update the CRC-8 with the byte. Polynomial x^8+x^2+x+1 (0x07), initial value 0x00, MSB first.
  - Index 4: latch `hec_bad = (rx_data != crc ^ HEC_COSET)`.
  - Capture with `rx_soc`=1 at index ≠ 0:
    - `runt_cnt`++.
    - Discard the partial cell.
    - Treat the byte as index 0 of a new cell in the same buffer.
  - Capture of index `CELL_BYTES-1`:
    - `rx_en`=1 at the same edge.
    - If `hec_bad`=1: discard the buffer and `hec_err_cnt`++.
    - Otherwise: mark the buffer full, `cell_cnt`++, toggle the write pointer.
    - Return to IDLE.
- `rx_clav` is ignored once HUNT is entered.

Buffers:
- Two 53-byte entries.
- Write pointer and read pointer are 1 bit each, plus a full flag per entry.
- Cells leave in arrival order.
- When both entries are full, the FSM stays in IDLE with `rx_en`=1.

Output:
- The read side streams the oldest full entry, byte 0 to byte 52.
- The byte index advances on `out_valid && out_ready`.
- On the transfer of byte 52: clear that entry's full flag and toggle the read pointer.
- `out_valid` holds its value and `out_data` holds stable while `out_ready`=0.

Counters saturate at all-ones and never wrap.

## Timing

Values after reset:
- `rx_en`=1.
- `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_data`=0.
- All counters 0.
- Both buffers empty, FSM in IDLE.
- Any partial cell is discarded.

A reset asserted mid-cell or mid-output takes effect at the next edge with the same result.

Cycle timing:
- `rx_clav` seen high at edge T (IDLE, buffer free) gives `rx_en`=0 from edge T. The first capture is at edge T+1.
- A cell sent with no gaps occupies 53 consecutive capture edges, C0 to C52. `rx_en` returns to 1 at C52.
- Commit latency:
  - `out_valid` rises at edge C52+1 if the read side was idle.
  - `out_data` equals byte 0 with `out_sop`=1.
- Output throughput with `out_ready` held at 1: one byte per cycle.
  - A second full buffer starts at the edge after byte 52 of the first is accepted.
- Releasing a buffer and starting a new cell on the same edge is allowed. The freed entry counts as free on the following edge.
- Minimum Rx turnaround, C52 to the next `rx_en`=0: 1 edge, provided `rx_clav`=1 and a buffer is free.

## Test plan

- **Good cell.**
  - Stimulus: header 00 00 00 00, HEC 0x55, payload 0x01–0x30, `out_ready`=1.
  - Response: 53 bytes out in order, `out_sop` on byte 0 and `out_eop` on byte 52, `cell_cnt`=1, first `out_valid` at C52+1.
- **HEC error.**
  - Stimulus: header 00 00 00 01 with HEC 0x55 (correct value is 0x52).
  - Response: no `out_valid`, `hec_err_cnt`=1. A following cell with header 00 00 00 01 and HEC 0x52 is forwarded.
- **Runt.**
  - Stimulus: `rx_soc` reasserted at index 20, then a full good cell.
  - Response: `runt_cnt`=1, exactly one 53-byte cell out, which is the second one.
- **Back-pressure.**
  - Stimulus: `out_ready`=0, three good cells offered.
  - Response: two cells are captured and `rx_en` stays 1. After `out_ready`=1, both cells come out in order, then the third cell is captured.
- **Hunt.**
  - Stimulus: 3 captured bytes with `rx_soc`=0, then a cell starting with `rx_soc`=1.
  - Response: the 3 bytes are dropped, one correct cell out, no counters except `cell_cnt` change.
- **Reset mid-cell.**
  - Stimulus: `rst_n`=0 for one edge at index 30.
  - Response: next edge shows `rx_en`=1, `out_valid`=0, counters 0. A subsequent cell is received normally.

Source files
------------

// File: rtl/utopia_rx_port.sv
// utopia_rx_port: UTOPIA L1 receive front end with HEC check, ping-pong cell buffer and byte stream out
module utopia_rx_port #(
  parameter int         CELL_BYTES = 53,
  parameter logic [7:0] HEC_COSET  = 8'h55,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_soc,
  input  logic [7:0]       rx_data,
  input  logic             rx_clav,
  output logic             rx_en,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cell_cnt,
  output logic [CNT_W-1:0] hec_err_cnt,
  output logic [CNT_W-1:0] runt_cnt
);
  localparam int IW = $clog2(CELL_BYTES + 1);
  localparam logic [IW-1:0] LAST = IW'(CELL_BYTES - 1);
  localparam logic [IW-1:0] NBYTES = IW'(CELL_BYTES);
  typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;
  state_t state, state_d;
  logic [7:0] mem [2][CELL_BYTES];
  logic [1:0] full;
  logic wr_ptr, rd_ptr, hec_bad;
  logic [IW-1:0] idx, ridx, src_idx;
  logic [7:0] crc;
  logic cap, start, runt, wr, last, commit, drop, xfer_eop, ld, src_ptr, avail;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end

  always_comb begin
    state_d = state == IDLE ? ((rx_clav && !full[wr_ptr]) ? HUNT : IDLE)
            : state == HUNT ? ((cap && rx_soc) ? RECV : HUNT)
            : ((commit || drop) ? IDLE : RECV);
  end

  always_comb begin
    cap    = !rx_en;
    last   = idx == LAST;
    start  = cap && rx_soc && state != IDLE;
    runt   = start && state == RECV;
    wr     = cap && !rx_soc && state == RECV;
    commit = wr && last && !hec_bad;
    drop   = wr && last && hec_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rx_en <= 1'b1;
    else rx_en <= state_d == IDLE;
  end

  always_ff @(posedge clk) begin
    if (start || wr) mem[wr_ptr][start ? '0 : idx] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= 1'b0;
      idx         <= '0;
      crc         <= '0;
      hec_bad     <= 1'b0;
      full        <= '0;
      cell_cnt    <= '0;
      hec_err_cnt <= '0;
      runt_cnt    <= '0;
    end else begin
      if (start) begin
        idx <= IW'(1);
        crc <= crc8(8'h00, rx_data);
      end else if (wr) begin
        idx <= idx + IW'(1);
        if (idx < IW'(4)) crc <= crc8(crc, rx_data);
        if (idx == IW'(4)) hec_bad <= rx_data != (crc ^ HEC_COSET);
      end
      if (commit) wr_ptr <= ~wr_ptr;
      if (xfer_eop) full[rd_ptr] <= 1'b0;
      if (commit) full[wr_ptr] <= 1'b1;
      if (commit && !(&cell_cnt)) cell_cnt <= cell_cnt + CNT_W'(1);
      if (drop && !(&hec_err_cnt)) hec_err_cnt <= hec_err_cnt + CNT_W'(1);
      if (runt && !(&runt_cnt)) runt_cnt <= runt_cnt + CNT_W'(1);
    end
  end

  // the entry being released on this edge hands straight over to the other one
  always_comb begin
    xfer_eop = out_valid && out_ready && out_eop;
    ld       = !out_valid || out_ready;
    src_ptr  = rd_ptr ^ xfer_eop;
    src_idx  = xfer_eop ? '0 : ridx;
    avail    = full[src_ptr] && src_idx < NBYTES;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      rd_ptr    <= 1'b0;
      ridx      <= '0;
    end else if (ld) begin
      out_valid <= avail;
      rd_ptr    <= src_ptr;
      ridx      <= src_idx + IW'(avail);
      out_sop   <= avail && src_idx == '0;
      out_eop   <= avail && src_idx == LAST;
      if (avail) out_data <= mem[src_ptr][src_idx];
    end
  end
endmodule
